fifo_rd_stream: RTL and testbench

- Downstream read-side stage of the async FIFO, in the FIFO read clock domain.
- Converts the FIFO pop interface (rd_en, empty, dout, one-cycle read latency) into a ready/valid stream for consumers such as the UART transmitter and the CPU MMIO read path.
- Holds prefetched words in a small skid buffer, so the stream sustains one word per cycle with no data loss under backpressure.
- Keeps a delivered-word counter for debug.

---
 rtl/fifo_rd_stream_if.sv | 37 +++
 rtl/fifo_rd_stream.sv | 90 +++++++++
 tb/tb_fifo_rd_stream.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO pop side plus ready/valid stream plus counter.
// master = stage view, slave = FIFO/consumer/debug view.
interface fifo_rd_stream_if #(
  parameter int data_width = 8,
  parameter int cnt_width  = 32
);
  logic                  fifo_empty;
  logic [data_width-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_data;
  logic                  cnt_clr;
  logic [cnt_width-1:0]  word_count;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  out_ready,
    input  cnt_clr,
    output fifo_rd_en,
    output out_valid,
    output out_data,
    output word_count
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output out_ready,
    output cnt_clr,
    input  fifo_rd_en,
    input  out_valid,
    input  out_data,
    input  word_count
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO read side (1-cycle latency) to ready/valid stream.
// Ports: clk, rst_n (async, low), bus (fifo_*, out_*, cnt_clr, word_count).
module fifo_rd_stream #(
  parameter int data_width = 8,
  parameter int buf_depth  = 2,
  parameter int cnt_width  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_rd_stream_if.master bus
);
  // buf_depth is limited to 2..4, so 2 pointer bits and 3 occupancy
  // bits always suffice; the level below never exceeds buf_depth.
  localparam int PW = (buf_depth > 2) ? 2 : 1;
  localparam int OW = 3;
  localparam logic [PW-1:0] LAST = PW'(buf_depth - 1);
  localparam logic [OW-1:0] FULL = OW'(buf_depth);

  logic [data_width-1:0] r_mem [buf_depth];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [OW-1:0]         r_occ;
  logic                  r_inflight;
  logic [cnt_width-1:0]  r_cnt;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_rd_en;
  logic [OW-1:0]         w_level;
  logic [PW-1:0]         w_rd_nxt;
  logic [PW-1:0]         w_wr_nxt;

  assign w_pop  = (r_occ != '0) && bus.out_ready;
  assign w_push = r_inflight;

  // Occupancy as it will be once the word in flight lands and the
  // current pop retires; reading only while this is below depth makes
  // overflow impossible while still refilling on the pop cycle.
  assign w_level = r_occ
                 + {{(OW-1){1'b0}}, r_inflight}
                 - {{(OW-1){1'b0}}, w_pop};

  // rst_n gates the request so the FIFO sees no read during reset.
  assign w_rd_en = rst_n && !bus.fifo_empty && (w_level < FULL);

  assign w_rd_nxt = (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_nxt = (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.out_valid  = (r_occ != '0);
  assign bus.out_data   = r_mem[r_rd_ptr];
  assign bus.word_count = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_occ      <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_inflight <= w_rd_en;
      r_occ      <= r_occ
                  + {{(OW-1){1'b0}}, w_push}
                  - {{(OW-1){1'b0}}, w_pop};
      if (w_push) r_wr_ptr <= w_wr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
    end
  end

  // Storage is cleared so out_data reads 0 until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < buf_depth; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= bus.fifo_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_cnt <= '0;
    else if (bus.cnt_clr) r_cnt <= '0;
    else if (w_pop)       r_cnt <= r_cnt + 1'b1;
  end

`ifndef SYNTHESIS
  a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_occ == FULL) && !w_pop));
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed table plus corner sequences for
// fifo_rd_stream, with a FIFO model and an output monitor.
module tb_fifo_rd_stream;
  logic clk;
  logic rst_n;
  logic stall;

  fifo_rd_stream_if #(.data_width(8), .cnt_width(32)) bus ();
  fifo_rd_stream_if #(.data_width(8), .cnt_width(4))  nb ();

  fifo_rd_stream #(
    .data_width(8), .buf_depth(2), .cnt_width(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  // Narrow-counter copy fed with identical inputs for the wrap check.
  fifo_rd_stream #(
    .data_width(8), .buf_depth(2), .cnt_width(4)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .bus(nb.master)
  );

  assign nb.fifo_empty = bus.fifo_empty;
  assign nb.fifo_dout  = bus.fifo_dout;
  assign nb.out_ready  = bus.out_ready;
  assign nb.cnt_clr    = bus.cnt_clr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model: one-cycle read latency, stall forces empty.
  logic [7:0] fmem [0:2047];
  int hd = 0;
  int tl = 0;

  assign bus.fifo_empty = stall || (hd == tl);

  always @(posedge clk) begin
    if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_dout <= fmem[hd];
      hd <= hd + 1;
    end
  end

  // Output monitor.
  logic [7:0] got [0:2047];
  int gn = 0;

  always @(posedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      got[gn] <= bus.out_data;
      gn <= gn + 1;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!bus.out_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(bus.out_valid), 32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic       stl;
    logic       rdy;
    logic       e_rd;
    logic       e_v;
    logic       ck_d;
    logic [7:0] e_d;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic s, input logic y,
                     input logic erd, input logic ev, input logic ck,
                     input logic [7:0] d);
    vec_t v;
    v.rst = r; v.stl = s; v.rdy = y;
    v.e_rd = erd; v.e_v = ev; v.ck_d = ck; v.e_d = d;
    tv.push_back(v);
  endtask

  int base;
  int errs;

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    bus.out_ready = 1'b1;
    bus.cnt_clr = 1'b0;
    for (int i = 0; i < 16; i++) fmem[i] = 8'(i + 1);
    for (int i = 0; i < 5; i++) fmem[16 + i] = 8'(i + 1);
    tl = 21;

    // Reset, then 16-beat stream.
    add(0, 0, 1, 0, 0, 1, 8'h00);
    add(0, 0, 1, 0, 0, 1, 8'h00);
    add(1, 0, 1, 1, 0, 1, 8'h00);
    add(1, 0, 1, 1, 0, 1, 8'h00);
    for (int k = 1; k <= 14; k++) add(1, 0, 1, 1, 1, 1, 8'(k));
    add(1, 1, 1, 0, 1, 1, 8'h0f);
    add(1, 1, 1, 0, 1, 1, 8'h10);
    add(1, 1, 1, 0, 0, 0, 8'h00);
    // Backpressure with 5 words queued.
    add(1, 0, 0, 1, 0, 0, 8'h00);
    add(1, 0, 0, 1, 0, 0, 8'h00);
    add(1, 0, 0, 0, 1, 1, 8'h01);
    add(1, 0, 0, 0, 1, 1, 8'h01);
    add(1, 0, 0, 0, 1, 1, 8'h01);
    add(1, 0, 1, 1, 1, 1, 8'h01);
    add(1, 0, 1, 1, 1, 1, 8'h02);
    add(1, 0, 1, 1, 1, 1, 8'h03);
    add(1, 0, 1, 0, 1, 1, 8'h04);
    add(1, 0, 1, 0, 1, 1, 8'h05);
    add(1, 0, 1, 0, 0, 0, 8'h00);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst_n = tv[i].rst;
      stall = tv[i].stl;
      bus.out_ready = tv[i].rdy;
      #1;
      chk($sformatf("v%0d_rd", i), 32'(bus.fifo_rd_en), 32'(tv[i].e_rd));
      chk($sformatf("v%0d_vld", i), 32'(bus.out_valid), 32'(tv[i].e_v));
      if (tv[i].ck_d)
        chk($sformatf("v%0d_dat", i), 32'(bus.out_data), 32'(tv[i].e_d));
      if (i < 2)
        chk($sformatf("v%0d_cnt", i), bus.word_count, 32'd0);
      if (i == 20) begin
        chk("stream_cnt", bus.word_count, 32'd16);
        chk("wrap_cnt", 32'(nb.word_count), 32'd0);
      end
    end
    chk("bp_cnt", bus.word_count, 32'd21);
    chk("bp_ncnt", 32'(nb.word_count), 32'd5);

    // Clear in the same cycle as a pop.
    fmem[21] = 8'h77;
    tl = 22;
    bus.out_ready = 1'b1;
    wait_valid("clr_wait");
    chk("clr_dat", 32'(bus.out_data), 32'h77);
    bus.cnt_clr = 1'b1;
    @(negedge clk);
    #1;
    bus.cnt_clr = 1'b0;
    chk("clr_cnt", bus.word_count, 32'd0);
    chk("clr_ncnt", 32'(nb.word_count), 32'd0);
    chk("clr_mon", 32'(got[gn - 1]), 32'h77);

    // Random FIFO stalls and consumer backpressure.
    for (int i = 0; i < 1000; i++) fmem[22 + i] = 8'($urandom);
    base = gn;
    tl = 1022;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (gn - base >= 1000) break;
      stall = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
    end
    stall = 1'b0;
    bus.out_ready = 1'b0;
    chk("rand_len", 32'(gn - base), 32'd1000);
    errs = 0;
    for (int i = 0; i < 1000; i++)
      if (got[base + i] !== fmem[22 + i]) errs++;
    chk("rand_seq", 32'(errs), 32'd0);
    chk("rand_cnt", bus.word_count, 32'd1000);
    chk("rand_ncnt", 32'(nb.word_count), 32'd8);

    // Reset with one word buffered and one in flight.
    fmem[1022] = 8'ha1;
    fmem[1023] = 8'ha2;
    fmem[1024] = 8'ha3;
    fmem[1025] = 8'ha4;
    tl = 1026;
    #1;
    chk("mr_rd0", 32'(bus.fifo_rd_en), 32'd1);
    @(negedge clk);
    #1;
    chk("mr_rd1", 32'(bus.fifo_rd_en), 32'd1);
    @(negedge clk);
    #1;
    chk("mr_rd2", 32'(bus.fifo_rd_en), 32'd0);
    chk("mr_pre", 32'(bus.out_data), 32'ha1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_vld", 32'(bus.out_valid), 32'd0);
    chk("mr_rdr", 32'(bus.fifo_rd_en), 32'd0);
    chk("mr_dat", 32'(bus.out_data), 32'd0);
    chk("mr_cnt", bus.word_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("mr_rel", 32'(bus.fifo_rd_en), 32'd1);
    wait_valid("mr_wait");
    chk("mr_w3", 32'(bus.out_data), 32'ha3);
    @(negedge clk);
    #1;
    chk("mr_v4", 32'(bus.out_valid), 32'd1);
    chk("mr_w4", 32'(bus.out_data), 32'ha4);
    @(negedge clk);
    #1;
    chk("mr_end", 32'(bus.out_valid), 32'd0);
    chk("mr_ecnt", bus.word_count, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
